// File: rtl/chrono_if.sv
// Button inputs and display/status outputs of the chronometer time base.
// The counter attaches as slave; the button/display side attaches as master.
interface chrono_if;
  logic        btn_ss_i;
  logic        btn_lap_i;
  logic        btn_clr_i;
  logic [15:0] value;
  logic        running_o;
  logic        lap_o;
  logic        tick_o;
  logic        overflow_o;

  modport master (
    output btn_ss_i, btn_lap_i, btn_clr_i,
    input  value, running_o, lap_o, tick_o, overflow_o
  );

  modport slave (
    input  btn_ss_i, btn_lap_i, btn_clr_i,
    output value, running_o, lap_o, tick_o, overflow_o
  );
endinterface

// File: rtl/chrono_counter.sv
// Chronometer time base: debounced start/stop, lap and clear buttons, 10 ms prescaler
// and a packed-BCD SS.CC counter with lap freeze and sticky overflow.
module chrono_counter #(
  parameter int unsigned CLK_FPGA        = 100000000,
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic     clk_i,
  input  logic     rst_i,
  chrono_if.slave  bus
);

  // TICK_DIV of 0 derives the 10 ms divider from the clock frequency.
  localparam int unsigned TickDiv = (TICK_DIV != 0) ? TICK_DIV : CLK_FPGA / 100;
  localparam int unsigned PW      = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

  state_e              state_q, state_d;
  logic [2:0]          btn_raw, sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, events;
  logic [2:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [15:0]         count_q, count_d, lap_q, lap_d;
  logic                overflow_q, overflow_d;
  logic                ev_ss, ev_lap, ev_clr;
  logic                counting, tick, do_clr, do_capture;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] != 4'd5) ? v[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  assign btn_raw = {bus.btn_clr_i, bus.btn_lap_i, bus.btn_ss_i};

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i]     = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  assign events = deb_q & ~deb_prev_q;
  assign ev_ss  = events[0];
  assign ev_lap = events[1];
  assign ev_clr = events[2];

  // Only the highest-priority pending event is considered; if illegal it is simply dropped.
  always_comb begin
    state_d    = state_q;
    do_clr     = 1'b0;
    do_capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ev_clr && ev_ss) state_d = StRun;
      end
      StRun: begin
        if (!ev_clr) begin
          if (ev_ss) begin
            state_d = StPause;
          end else if (ev_lap) begin
            state_d    = StLap;
            do_capture = 1'b1;
          end
        end
      end
      StLap: begin
        if (!ev_clr) begin
          if (ev_ss)       state_d = StPause;
          else if (ev_lap) state_d = StRun;
        end
      end
      StPause: begin
        if (ev_clr) begin
          state_d = StIdle;
          do_clr  = 1'b1;
        end else if (ev_ss) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (presc_q == PW'(TickDiv - 1));

  always_comb begin
    presc_d    = presc_q;
    count_d    = count_q;
    lap_d      = lap_q;
    overflow_d = overflow_q;
    if (do_clr) begin
      presc_d    = '0;
      count_d    = '0;
      lap_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (counting) presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        count_d = bcd_inc(count_q);
        if (count_q == 16'h5999) overflow_d = 1'b1;
      end
      if (do_capture) lap_d = count_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
      presc_q    <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.value      = (state_q == StLap) ? lap_q : count_q;
  assign bus.running_o  = counting;
  assign bus.lap_o      = (state_q == StLap);
  assign bus.tick_o     = tick;
  assign bus.overflow_o = overflow_q;

endmodule
